// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for a sequential Y86-64 core: one-hot stage enables,
// memory-stage ready handshake with timeout, processor status register and counters.
module seq_stage_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       icode,
    input  logic             HLT,
    input  logic             INS,
    input  logic             ADR,
    input  logic             DataMemError,
    input  logic             Mem_Ready,
    output logic             Fetch_En,
    output logic             Decode_En,
    output logic             Execute_En,
    output logic             Memory_En,
    output logic             Writeback_En,
    output logic             PC_En,
    output logic             CC_En,
    output logic             Mem_Req,
    output logic [3:0]       Status,
    output logic             Halted,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic [CNT_W-1:0] Instr_Count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_ADR = 4'd2;
    localparam logic [3:0] STAT_INS = 4'd3;
    localparam logic [3:0] STAT_HLT = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_STOP      = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        status_q, status_d;
    logic              halted_q, halted_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic              mem_op_s;

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
    function automatic logic is_mem_op(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    endfunction

    // Next-state, status and counter logic
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        halted_d = halted_q;
        wait_d   = wait_q;
        cycle_d  = cycle_q;
        instr_d  = instr_q;
        mem_op_s = is_mem_op(icode);

        if ((state_q != S_IDLE) && (state_q != S_STOP) && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + CNT_W'(1);
        end else begin
            cycle_d = cycle_q;
        end

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: begin
                if (HLT) begin
                    status_d = STAT_HLT;
                    halted_d = 1'b1;
                    state_d  = S_STOP;
                end else if (INS) begin
                    status_d = STAT_INS;
                    halted_d = 1'b1;
                    state_d  = S_STOP;
                end else if (ADR) begin
                    status_d = STAT_ADR;
                    halted_d = 1'b1;
                    state_d  = S_STOP;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_MEMORY;
                wait_d  = '0;
            end
            S_MEMORY: begin
                if (!mem_op_s) begin
                    state_d = S_WRITEBACK;
                end else if (Mem_Ready) begin
                    // A completed access beats the timeout in the same cycle
                    if (DataMemError) begin
                        status_d = STAT_ADR;
                        halted_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    status_d = STAT_ADR;
                    halted_d = 1'b1;
                    state_d  = S_STOP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                state_d = S_FETCH;
                if (instr_q != CNT_MAX) instr_d = instr_q + CNT_W'(1);
                else                    instr_d = instr_q;
            end
            S_STOP:  state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
    end

    // State, status and counter registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            status_q <= STAT_AOK;
            halted_q <= 1'b0;
            wait_q   <= '0;
            cycle_q  <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
        end
    end

    // Moore stage enables decoded from the state register
    always_comb begin
        Fetch_En     = (state_q == S_FETCH);
        Decode_En    = (state_q == S_DECODE);
        Execute_En   = (state_q == S_EXECUTE);
        Memory_En    = (state_q == S_MEMORY);
        Writeback_En = (state_q == S_WRITEBACK);
        PC_En        = (state_q == S_PCUPD);
        CC_En        = (state_q == S_EXECUTE) && (icode == 4'h6);
        Mem_Req      = (state_q == S_MEMORY) && is_mem_op(icode);
        Status       = status_q;
        Halted       = halted_q;
        Cycle_Count  = cycle_q;
        Instr_Count  = instr_q;
    end

endmodule
